// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Fixed latency; a one-cycle RDY pulse marks the result, which then holds until the next result.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  multdiv_unit_if.slave mdu
);
  localparam int unsigned MULT_CYCLES = WIDTH / 2;
  localparam int unsigned DIV_CYCLES  = WIDTH;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic               op_div_q;
  logic [2*WIDTH:0]   p_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH+1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_q;
  logic               dz_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  logic [WIDTH+1:0]   mc_ext;
  logic [WIDTH+1:0]   hi_ext;
  logic [WIDTH+1:0]   addend;
  logic [WIDTH+1:0]   booth_sum;
  logic [2*WIDTH:0]   p_d;
  logic [WIDTH+1:0]   shl;
  logic [WIDTH+1:0]   dvs_ext;
  logic [WIDTH+1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_top;
  logic               start;

  assign start = mdu.ctrl_MULT | mdu.ctrl_DIV;

  always_comb begin
    a_mag = mdu.data_operandA[WIDTH-1] ? -mdu.data_operandA : mdu.data_operandA;
    b_mag = mdu.data_operandB[WIDTH-1] ? -mdu.data_operandB : mdu.data_operandB;
  end

  // Booth step: the accumulator is widened by two bits so +/-2A never overflows before
  // the arithmetic shift by 2 brings it back into WIDTH bits.
  always_comb begin
    mc_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    hi_ext = {{2{p_q[2*WIDTH]}}, p_q[2*WIDTH:WIDTH+1]};
    addend = '0;
    unique case (p_q[2:0])
      3'b001, 3'b010: addend = mc_ext;
      3'b011:         addend = mc_ext << 1;
      3'b100:         addend = -(mc_ext << 1);
      3'b101, 3'b110: addend = -mc_ext;
      default:        addend = '0;
    endcase
    booth_sum = hi_ext + addend;
    p_d       = {booth_sum, p_q[WIDTH:2]};
  end

  // Quotient bit is the sign of the new partial remainder, so the quotient needs no
  // correction; the remainder fix-up would only matter if the remainder were kept.
  always_comb begin
    dvs_ext = {2'b00, dvs_q};
    shl     = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
    rem_d   = rem_q[WIDTH+1] ? (shl + dvs_ext) : (shl - dvs_ext);
    quo_d   = {quo_q[WIDTH-2:0], ~rem_d[WIDTH+1]};
  end

  assign mul_top = p_q[2*WIDTH:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      p_q      <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        cnt_q <= '0;
        if (mdu.ctrl_MULT) begin
          state_q  <= MULT;
          op_div_q <= 1'b0;
          mcand_q  <= mdu.data_operandA;
          p_q      <= {{WIDTH{1'b0}}, mdu.data_operandB, 1'b0};
        end else begin
          state_q  <= DIV;
          op_div_q <= 1'b1;
          quo_q    <= a_mag;
          dvs_q    <= b_mag;
          rem_q    <= '0;
          neg_q    <= mdu.data_operandA[WIDTH-1] ^ mdu.data_operandB[WIDTH-1];
          dz_q     <= (mdu.data_operandB == '0);
          ovf_q    <= (mdu.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (mdu.data_operandB == '1);
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          MULT: begin
            p_q   <= p_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(MULT_CYCLES - 1)) state_q <= DONE;
          end
          DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_CYCLES - 1)) state_q <= DONE;
          end
          DONE: begin
            if (op_div_q) begin
              if (dz_q) begin
                result_q <= '0;
                exc_q    <= 1'b1;
              end else begin
                result_q <= neg_q ? -quo_q : quo_q;
                exc_q    <= ovf_q;
              end
            end else begin
              result_q <= p_q[WIDTH:1];
              exc_q    <= ~((&mul_top) | (~|mul_top));
            end
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mdu.data_result    = result_q;
  assign mdu.data_exception = exc_q;
  assign mdu.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit: latency, results, exceptions, abort, reset.
module tb_multdiv_unit;
  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  multdiv_unit_if #(.WIDTH(32)) mdu ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mdu     (mdu.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts an op at the next edge (edge 0) and watches 45 further edges.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int first_edge, output int n_rdy,
                        output logic [31:0] res, output logic exc);
    mdu.data_operandA = a;
    mdu.data_operandB = b;
    mdu.ctrl_MULT     = m;
    mdu.ctrl_DIV      = d;
    @(posedge clock); #1;
    mdu.ctrl_MULT     = 1'b0;
    mdu.ctrl_DIV      = 1'b0;
    mdu.data_operandA = $urandom;
    mdu.data_operandB = $urandom;
    first_edge = 0;
    n_rdy      = 0;
    res        = '0;
    exc        = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clock); #1;
      if (mdu.data_resultRDY) begin
        n_rdy++;
        if (n_rdy == 1) begin
          first_edge = e;
          res        = mdu.data_result;
          exc        = mdu.data_exception;
        end
      end
    end
  endtask

  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
    longint p;
    logic [63:0] pv;
    p   = longint'($signed(a)) * longint'($signed(b));
    pv  = p;
    res = pv[31:0];
    exc = (p != longint'($signed(pv[31:0])));
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
    if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      res = $signed(a) / $signed(b);
      exc = 1'b0;
    end
  endtask

  initial begin
    int          fe;
    int          nr;
    logic [31:0] res;
    logic        exc;
    logic [31:0] eres;
    logic        eexc;
    logic [31:0] ra;
    logic [31:0] rb;

    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    mdu.data_operandA = '0;
    mdu.data_operandB = '0;
    mdu.ctrl_MULT     = 1'b0;
    mdu.ctrl_DIV      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", 64'(mdu.data_result), 64'h0);
    check("rst_exc", 64'(mdu.data_exception), 64'h0);
    check("rst_rdy", 64'(mdu.data_resultRDY), 64'h0);
    reset_n = 1'b1;

    // Non-zero state before the mid-op reset
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd3, fe, nr, res, exc);
    check("pre_res", 64'(res), 64'h7FFF_FFFD);
    check("pre_exc", 64'(exc), 64'h1);

    // Reset mid-op
    mdu.data_operandA = 32'd7;
    mdu.data_operandB = 32'd6;
    mdu.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    mdu.ctrl_MULT     = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_result", 64'(mdu.data_result), 64'h0);
    check("midrst_exc", 64'(mdu.data_exception), 64'h0);
    check("midrst_rdy", 64'(mdu.data_resultRDY), 64'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    nr = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      if (mdu.data_resultRDY) nr++;
    end
    check("midrst_no_rdy", 64'(nr), 64'h0);
    check("midrst_result_after", 64'(mdu.data_result), 64'h0);

    // Multiply
    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, fe, nr, res, exc);
    check("mul_neg_edge", 64'(fe), 64'd17);
    check("mul_neg_nrdy", 64'(nr), 64'd1);
    check("mul_neg_res", 64'(res), 64'hFFFF_FFEB);
    check("mul_neg_exc", 64'(exc), 64'h0);

    nr = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock); #1;
      if (mdu.data_resultRDY) nr++;
    end
    check("hold_result", 64'(mdu.data_result), 64'hFFFF_FFEB);
    check("hold_no_rdy", 64'(nr), 64'h0);

    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, fe, nr, res, exc);
    check("mul_ovf_res", 64'(res), 64'h0);
    check("mul_ovf_exc", 64'(exc), 64'h1);

    // Divide
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, fe, nr, res, exc);
    check("div_neg_edge", 64'(fe), 64'd33);
    check("div_neg_nrdy", 64'(nr), 64'd1);
    check("div_neg_res", 64'(res), 64'hFFFF_FFFD);
    check("div_neg_exc", 64'(exc), 64'h0);

    run_op(1'b0, 1'b1, 32'd100, 32'd0, fe, nr, res, exc);
    check("div0_edge", 64'(fe), 64'd33);
    check("div0_res", 64'(res), 64'h0);
    check("div0_exc", 64'(exc), 64'h1);

    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, fe, nr, res, exc);
    check("divovf_edge", 64'(fe), 64'd33);
    check("divovf_res", 64'(res), 64'h8000_0000);
    check("divovf_exc", 64'(exc), 64'h1);

    // Abort DIV 100/3 by MULT 5*5 at edge 10
    mdu.data_operandA = 32'd100;
    mdu.data_operandB = 32'd3;
    mdu.ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    mdu.ctrl_DIV      = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    run_op(1'b1, 1'b0, 32'd5, 32'd5, fe, nr, res, exc);
    check("abort_edge", 64'(fe), 64'd17);
    check("abort_nrdy", 64'(nr), 64'd1);
    check("abort_res", 64'(res), 64'd25);
    check("abort_exc", 64'(exc), 64'h0);

    // Both start strobes: multiply wins
    run_op(1'b1, 1'b1, 32'd12, 32'd4, fe, nr, res, exc);
    check("both_edge", 64'(fe), 64'd17);
    check("both_res", 64'(res), 64'd48);

    // Random against reference model
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = {{28{rb[3]}}, rb[3:0]};
      if (i % 5 == 0) ra = {{20{ra[11]}}, ra[11:0]};
      run_op(1'b1, 1'b0, ra, rb, fe, nr, res, exc);
      ref_mul(ra, rb, eres, eexc);
      check("rnd_mul_res", 64'(res), 64'(eres));
      check("rnd_mul_exc", 64'(exc), 64'(eexc));
      check("rnd_mul_edge", 64'(fe), 64'd17);
      run_op(1'b0, 1'b1, ra, rb, fe, nr, res, exc);
      ref_div(ra, rb, eres, eexc);
      check("rnd_div_res", 64'(res), 64'(eres));
      check("rnd_div_exc", 64'(exc), 64'(eexc));
      check("rnd_div_edge", 64'(fe), 64'd33);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
